// File: rtl/midi_voice_parser.sv
// MIDI channel-voice parser: turns a received byte stream into registered
// note-on/note-off events, with running status, channel masking and a drop counter.
module midi_voice_parser #(
    parameter logic [15:0] CHANNEL_MASK  = 16'h0001,
    parameter bit          VEL0_IS_OFF   = 1'b1,
    parameter int          DROP_CNT_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     midiByteValid_i,
    input  logic [7:0]               midiByte_i,
    output logic [6:0]               note_o,
    output logic [6:0]               velocity_o,
    output logic [3:0]               channel_o,
    output logic                     noteOnStrb_o,
    output logic                     noteOffStrb_o,
    output logic [DROP_CNT_BITS-1:0] dropCnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, SYSX} state_t;

    localparam logic [DROP_CNT_BITS-1:0] DROP_ONE = DROP_CNT_BITS'(1);
    localparam logic [DROP_CNT_BITS-1:0] DROP_MAX = '1;

    state_t                   state_reg, state_next;
    logic [7:0]               run_status_reg, run_status_next;
    logic                     run_valid_reg, run_valid_next;
    logic [6:0]               data1_reg, data1_next;
    logic [6:0]               note_reg, note_next;
    logic [6:0]               vel_reg, vel_next;
    logic [3:0]               chan_reg, chan_next;
    logic                     on_reg, on_next;
    logic                     off_reg, off_next;
    logic [DROP_CNT_BITS-1:0] drop_reg, drop_next;

    logic       is_realtime, is_syscommon, is_status;
    logic [3:0] status_hi;
    logic       two_data_msg, note_msg, chan_accept;

    assign is_realtime  = (midiByte_i[7:3] == 5'b11111);
    assign is_syscommon = (midiByte_i[7:3] == 5'b11110);
    assign is_status    = midiByte_i[7] && (midiByte_i[7:4] != 4'hF);

    assign status_hi    = run_status_reg[7:4];
    // Program change and channel pressure carry one data byte; the rest carry two.
    assign two_data_msg = (status_hi != 4'hC) && (status_hi != 4'hD);
    assign note_msg     = (status_hi == 4'h8) || (status_hi == 4'h9);
    assign chan_accept  = CHANNEL_MASK[run_status_reg[3:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            run_status_reg <= '0;
            run_valid_reg  <= 1'b0;
            data1_reg      <= '0;
            note_reg       <= '0;
            vel_reg        <= '0;
            chan_reg       <= '0;
            on_reg         <= 1'b0;
            off_reg        <= 1'b0;
            drop_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            run_status_reg <= run_status_next;
            run_valid_reg  <= run_valid_next;
            data1_reg      <= data1_next;
            note_reg       <= note_next;
            vel_reg        <= vel_next;
            chan_reg       <= chan_next;
            on_reg         <= on_next;
            off_reg        <= off_next;
            drop_reg       <= drop_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        run_status_next = run_status_reg;
        run_valid_next  = run_valid_reg;
        data1_next      = data1_reg;
        note_next       = note_reg;
        vel_next        = vel_reg;
        chan_next       = chan_reg;
        on_next         = 1'b0;
        off_next        = 1'b0;
        drop_next       = drop_reg;

        if (midiByteValid_i && !is_realtime) begin
            if (is_status) begin
                run_status_next = midiByte_i;
                run_valid_next  = 1'b1;
                state_next      = WAIT1;
            end else if (is_syscommon) begin
                run_valid_next = 1'b0;
                state_next     = SYSX;
            end else if (state_reg == SYSX) begin
                state_next = SYSX;
            end else if (state_reg == IDLE || !run_valid_reg) begin
                if (drop_reg != DROP_MAX) begin
                    drop_next = drop_reg + DROP_ONE;
                end
            end else if (state_reg == WAIT1) begin
                if (two_data_msg) begin
                    data1_next = midiByte_i[6:0];
                    state_next = WAIT2;
                end
            end else begin
                state_next = WAIT1;
                if (note_msg && chan_accept) begin
                    note_next = data1_reg;
                    vel_next  = midiByte_i[6:0];
                    chan_next = run_status_reg[3:0];
                    if (status_hi == 4'h8 || (VEL0_IS_OFF && midiByte_i[6:0] == 7'd0)) begin
                        off_next = 1'b1;
                    end else begin
                        on_next = 1'b1;
                    end
                end
            end
        end
    end

    assign note_o        = note_reg;
    assign velocity_o    = vel_reg;
    assign channel_o     = chan_reg;
    assign noteOnStrb_o  = on_reg;
    assign noteOffStrb_o = off_reg;
    assign dropCnt_o     = drop_reg;

endmodule

// File: tb/tb_midi_voice_parser.sv
// Bench for midi_voice_parser: two differently parametrised instances share one
// byte stream and are checked every cycle against a message-level model.
module tb_midi_voice_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] byt = 8'h00;

    logic [6:0] a_note, a_vel, b_note, b_vel;
    logic [3:0] a_chan, b_chan;
    logic       a_on, a_off, b_on, b_off;
    logic [7:0] a_drop;
    logic [1:0] b_drop;

    int total = 0;
    int bad   = 0;

    // Instance A: channels 0 and 2, vel-0 is off. Instance B: channel 0 only, vel-0 is on, 2-bit counter.
    midi_voice_parser #(.CHANNEL_MASK(16'h0005), .VEL0_IS_OFF(1'b1), .DROP_CNT_BITS(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .midiByteValid_i(vld), .midiByte_i(byt),
        .note_o(a_note), .velocity_o(a_vel), .channel_o(a_chan),
        .noteOnStrb_o(a_on), .noteOffStrb_o(a_off), .dropCnt_o(a_drop));

    midi_voice_parser #(.CHANNEL_MASK(16'h0001), .VEL0_IS_OFF(1'b0), .DROP_CNT_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .midiByteValid_i(vld), .midiByte_i(byt),
        .note_o(b_note), .velocity_o(b_vel), .channel_o(b_chan),
        .noteOnStrb_o(b_on), .noteOffStrb_o(b_off), .dropCnt_o(b_drop));

    always #5 clk = ~clk;

    // Model: per instance, the current voice status (-1 when none), whether we are
    // inside a system message, and the data bytes collected for the current message.
    int m_mask[2]  = '{32'h0005, 32'h0001};
    int m_vel0[2]  = '{1, 0};
    int m_dmax[2]  = '{255, 3};
    int m_status[2];
    int m_sys[2];
    int m_cnt[2];
    int m_d1[2];
    int e_note[2], e_vel[2], e_chan[2], e_on[2], e_off[2], e_drop[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int hi, need, ch;
        for (int k = 0; k < 2; k++) begin
            e_on[k]  = 0;
            e_off[k] = 0;
            if (rst) begin
                m_status[k] = -1; m_sys[k] = 0; m_cnt[k] = 0; m_d1[k] = 0;
                e_note[k] = 0; e_vel[k] = 0; e_chan[k] = 0; e_drop[k] = 0;
            end else if (vld) begin
                if (byt >= 8'hF8) begin
                    // real-time: no effect
                end else if (byt >= 8'hF0) begin
                    m_status[k] = -1; m_sys[k] = 1; m_cnt[k] = 0;
                end else if (byt >= 8'h80) begin
                    m_status[k] = int'(byt); m_sys[k] = 0; m_cnt[k] = 0;
                end else if (m_sys[k] != 0) begin
                    // system message payload: ignored uncounted
                end else if (m_status[k] < 0) begin
                    if (e_drop[k] < m_dmax[k]) e_drop[k]++;
                end else begin
                    hi   = m_status[k] / 16;
                    ch   = m_status[k] % 16;
                    need = (hi == 12 || hi == 13) ? 1 : 2;
                    if (m_cnt[k] == 0) m_d1[k] = int'(byt);
                    m_cnt[k]++;
                    if (m_cnt[k] == need) begin
                        m_cnt[k] = 0;
                        if (need == 2 && (hi == 8 || hi == 9) && ((m_mask[k] >> ch) & 1) == 1) begin
                            e_note[k] = m_d1[k];
                            e_vel[k]  = int'(byt);
                            e_chan[k] = ch;
                            if (hi == 8 || (byt == 8'h00 && m_vel0[k] == 1)) e_off[k] = 1;
                            else e_on[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("a_note", int'(a_note), e_note[0]);
        chk("a_vel",  int'(a_vel),  e_vel[0]);
        chk("a_chan", int'(a_chan), e_chan[0]);
        chk("a_on",   int'(a_on),   e_on[0]);
        chk("a_off",  int'(a_off),  e_off[0]);
        chk("a_drop", int'(a_drop), e_drop[0]);
        chk("b_note", int'(b_note), e_note[1]);
        chk("b_vel",  int'(b_vel),  e_vel[1]);
        chk("b_chan", int'(b_chan), e_chan[1]);
        chk("b_on",   int'(b_on),   e_on[1]);
        chk("b_off",  int'(b_off),  e_off[1]);
        chk("b_drop", int'(b_drop), e_drop[1]);
        chk("a_excl", int'(a_on & a_off), 0);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk); vld = 1'b1; byt = b;
        @(negedge clk); vld = 1'b0;
        $display("byte %02h -> A on=%0d off=%0d n=%02h v=%02h c=%0d d=%0d | B on=%0d off=%0d d=%0d",
                 b, a_on, a_off, a_note, a_vel, a_chan, a_drop, b_on, b_off, b_drop);
    endtask

    task automatic burst(input logic [7:0] bs[$]);
        foreach (bs[i]) begin
            @(negedge clk); vld = 1'b1; byt = bs[i];
        end
        @(negedge clk); vld = 1'b0;
        $display("burst of %0d -> A on=%0d off=%0d n=%02h v=%02h c=%0d | B on=%0d off=%0d",
                 bs.size(), a_on, a_off, a_note, a_vel, a_chan, b_on, b_off);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    int drop_a_exp[5] = '{1, 2, 3, 4, 5};
    int drop_b_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_note", int'(a_note), 0);
        chk("rst_drop", int'(a_drop), 0);
        chk("rst_strb", int'(a_on | a_off | b_on | b_off), 0);

        // Basic note-on on channel 0
        send(8'h90); send(8'h3C); send(8'h64);
        chk("lit_on",   int'(a_on), 1);
        chk("lit_note", int'(a_note), 8'h3C);
        chk("lit_vel",  int'(a_vel), 8'h64);
        chk("lit_chan", int'(a_chan), 0);
        @(negedge clk);
        chk("lit_on_width", int'(a_on), 0);

        // Running status on channel 2; B masks channel 2
        burst('{8'h92, 8'h40, 8'h7F, 8'h41, 8'h00});
        chk("lit_rs_off",  int'(a_off), 1);
        chk("lit_rs_note", int'(a_note), 8'h41);
        chk("lit_rs_chan", int'(a_chan), 2);
        chk("lit_b_keep",  int'(b_note), 8'h3C);

        // Real-time interleave
        burst('{8'h80, 8'hF8, 8'h3C, 8'hFE, 8'h10});
        chk("lit_rt_off",  int'(a_off), 1);
        chk("lit_rt_vel",  int'(a_vel), 8'h10);
        chk("lit_rt_drop", int'(a_drop), 0);

        // Velocity 0 on channel 0: off for A, on for B
        send(8'h90); send(8'h3C); send(8'h00);
        chk("lit_v0_a", int'(a_off), 1);
        chk("lit_v0_b", int'(b_on), 1);

        // Filtering and skipping
        burst('{8'h91, 8'h30, 8'h40});
        chk("lit_mask", int'(a_on | a_off), 0);
        burst('{8'hC0, 8'h05, 8'h06, 8'hB0, 8'h07, 8'h08, 8'hE0, 8'h01, 8'h02});
        burst('{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h20});
        chk("lit_sysx_drop", int'(a_drop), 0);

        // Strobe in flight survives an immediate status byte
        burst('{8'h90, 8'h22, 8'h33, 8'h80, 8'h22, 8'h11, 8'h23, 8'h12});

        // Drop counter and saturation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'h10);
            chk("lit_drop_a", int'(a_drop), drop_a_exp[i]);
            chk("lit_drop_b", int'(b_drop), drop_b_exp[i]);
        end

        // Abort by new status, then reset mid-message
        do_reset();
        burst('{8'h90, 8'h3C, 8'h80, 8'h50, 8'h20});
        chk("lit_abort_off",  int'(a_off), 1);
        chk("lit_abort_note", int'(a_note), 8'h50);
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        chk("lit_rst_strb", int'(a_on | a_off), 0);
        chk("lit_rst_drop", int'(a_drop), 1);

        // Reset coincident with a valid byte
        @(negedge clk); rst = 1'b1; vld = 1'b1; byt = 8'h10;
        @(negedge clk); rst = 1'b0; vld = 1'b0;
        chk("lit_rst_prio", int'(a_drop), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
